// File: rtl/bus_master_port.sv
// Single-word bus initiator: requests the shared bus, drives the address and data phases,
// waits for slave ready, then reports read data or an error with a one-cycle response pulse.
module bus_master_port #(
    parameter int BUS_WIDTH  = 32,
    parameter int CTRL_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_L,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [BUS_WIDTH-1:0]  cmd_addr,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [BUS_WIDTH-1:0]  rsp_rdata,
    output logic                  req,
    input  logic                  ack,
    output logic [BUS_WIDTH-1:0]  bus_out,
    output logic [CTRL_WIDTH-1:0] ctrl_out,
    input  logic [BUS_WIDTH-1:0]  bus_in,
    input  logic [CTRL_WIDTH-1:0] ctrl_in,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_ADDR  = 3'd2,
        S_WDATA = 3'd3,
        S_RWAIT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0]            TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [CTRL_WIDTH-1:0] CTRL_WDATA  = CTRL_WIDTH'(8'h06);

    state_t               r_state;
    logic                 r_we;
    logic [BUS_WIDTH-1:0] r_addr;
    logic [BUS_WIDTH-1:0] r_wdata;
    logic [7:0]           r_cnt;

    logic       w_ready;
    logic [7:0] w_cnt_inc;
    logic       w_timeout;
    logic       w_end;
    logic       w_err;
    logic       w_unused;

    assign w_ready     = ctrl_in[3];
    assign w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_timeout   = (w_cnt_inc >= TIMEOUT_CNT);
    assign o_dbg_state = r_state;
    assign w_unused    = ^{ctrl_in[CTRL_WIDTH-1:4], ctrl_in[2:0]};

    // Exit decision for the granted states; slave ready outranks grant loss, which outranks timeout.
    always_comb begin
        w_end = 1'b0;
        w_err = 1'b0;
        case (r_state)
            S_ADDR: begin
                w_end = !ack;
                w_err = 1'b1;
            end
            S_WDATA, S_RWAIT: begin
                w_end = w_ready || !ack || w_timeout;
                w_err = !w_ready;
            end
            default: begin
                w_end = 1'b0;
                w_err = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            req       <= 1'b0;
            bus_out   <= '0;
            ctrl_out  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            cmd_ready <= 1'b1;
        end else if (w_end) begin
            req       <= 1'b0;
            bus_out   <= '0;
            ctrl_out  <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= w_err;
            r_state   <= S_DONE;
            if (r_state == S_RWAIT && w_ready) begin
                rsp_rdata <= bus_in;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_we      <= cmd_we;
                        r_addr    <= cmd_addr;
                        r_wdata   <= cmd_wdata;
                        req       <= 1'b1;
                        cmd_ready <= 1'b0;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        bus_out  <= r_addr;
                        ctrl_out <= {{(CTRL_WIDTH-2){1'b0}}, r_we, 1'b1};
                        r_state  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_cnt <= '0;
                    if (r_we) begin
                        bus_out  <= r_wdata;
                        ctrl_out <= CTRL_WDATA;
                        r_state  <= S_WDATA;
                    end else begin
                        bus_out  <= '0;
                        ctrl_out <= '0;
                        r_state  <= S_RWAIT;
                    end
                end
                S_WDATA, S_RWAIT: begin
                    r_cnt <= w_cnt_inc;
                end
                S_DONE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: directed scenarios plus randomized transactions, each predicted
// at transaction level (wait length, error, read data) and checked cycle by cycle.
module tb_bus_master_port;

    localparam int BW = 32;
    localparam int CW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_L;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [BW-1:0] cmd_addr;
    logic [BW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [BW-1:0] rsp_rdata;
    logic          req;
    logic          ack;
    logic [BW-1:0] bus_out;
    logic [CW-1:0] ctrl_out;
    logic [BW-1:0] bus_in;
    logic [CW-1:0] ctrl_in;
    logic [2:0]    dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    logic [BW:0]   exp_q[$];
    logic [BW-1:0] m_rdata;

    bus_master_port #(.BUS_WIDTH(BW), .CTRL_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_L(rst_L),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .req(req), .ack(ack), .bus_out(bus_out), .ctrl_out(ctrl_out),
        .bus_in(bus_in), .ctrl_in(ctrl_in), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One full transaction. ack_dly: REQ cycles with ack low before the grant.
    // rdy_at: wait cycle (1-based) carrying slave ready, 0 = never.
    // drop_at: 1 = grant lost in ADDR, n>1 = grant lost in wait cycle n-1, 0 = never.
    task automatic run_txn(input logic we, input logic [BW-1:0] addr, input logic [BW-1:0] wdata,
                           input int ack_dly, input int rdy_at, input int drop_at,
                           input logic [BW-1:0] rd_val);
        int          n_wait;
        logic        err;
        logic [BW:0] e;
        n_wait = TO;
        if (drop_at == 1) begin
            n_wait = 0;
        end else begin
            if (drop_at > 1 && drop_at - 1 < n_wait) n_wait = drop_at - 1;
            if (rdy_at > 0 && rdy_at <= n_wait) n_wait = rdy_at;
        end
        err = !(rdy_at != 0 && n_wait == rdy_at);
        if (!err && !we) m_rdata = rd_val;
        exp_q.push_back({err, m_rdata});

        check("idle_ready", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(negedge clk);
        for (int i = 0; i <= ack_dly; i++) begin
            check("req_phase", {22'd0, cmd_ready, req, ctrl_out, bus_out}, {22'd0, 1'b0, 1'b1, 8'h00, 32'h0});
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_we    = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            ack       = (i == ack_dly);
            @(negedge clk);
        end
        check("addr_phase", {23'd0, req, ctrl_out, bus_out}, {23'd0, 1'b1, 6'b0, we, 1'b1, addr});
        ack = (drop_at != 1);
        @(negedge clk);
        for (int w = 1; w <= n_wait; w++) begin
            if (we)
                check("wdata_phase", {21'd0, cmd_ready, req, rsp_valid, ctrl_out, bus_out},
                      {21'd0, 1'b0, 1'b1, 1'b0, 8'h06, wdata});
            else
                check("rwait_phase", {21'd0, cmd_ready, req, rsp_valid, ctrl_out, bus_out},
                      {21'd0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0});
            ctrl_in = {4'h0, (w == rdy_at), 3'($urandom_range(0, 7))};
            bus_in  = (w == rdy_at) ? rd_val : $urandom;
            ack     = !(drop_at > 1 && w + 1 >= drop_at);
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check("done_pulse", {21'd0, rsp_valid, req, cmd_ready, ctrl_out, bus_out}, {21'd0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0});
        check("done_resp", {31'd0, rsp_err, rsp_rdata}, {31'd0, e});
        cmd_valid = 1'b0;
        ack       = 1'b0;
        ctrl_in   = '0;
        bus_in    = $urandom;
        @(negedge clk);
        check("back_idle", {60'd0, rsp_valid, rsp_err, cmd_ready, req}, 64'b0010);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {59'd0, req, cmd_ready, rsp_valid, rsp_err, 1'b0}, {59'd0, 5'b01000});
        check({tag, "_bus"}, {24'd0, ctrl_out, bus_out}, 64'd0);
        check({tag, "_rdata"}, {32'd0, rsp_rdata}, 64'd0);
    endtask

    initial begin
        rst_L     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        ack       = 1'b0;
        bus_in    = '0;
        ctrl_in   = '0;
        m_rdata   = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_L = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {62'd0, cmd_ready, req}, 64'b10);

        run_txn(1'b0, 32'h0000_0010, 32'h0, 2, 1, 0, 32'hDEAD_BEEF);   // read, ready in 1st wait
        run_txn(1'b1, 32'h0000_0004, 32'h1234_5678, 0, 5, 0, 32'h0);   // write, ready after 5
        run_txn(1'b0, 32'h0000_0040, 32'h0, 1, 0, 0, 32'h1111_2222);   // read timeout
        run_txn(1'b1, 32'h0000_0044, 32'hCAFE_F00D, 0, 0, 3, 32'h0);   // grant lost 2nd WDATA
        run_txn(1'b0, 32'h0000_0048, 32'h0, 0, 2, 0, 32'h5555_AAAA);   // next command normal
        run_txn(1'b0, 32'h0000_004C, 32'h0, 0, 1, 1, 32'h7777_7777);   // grant lost in ADDR
        run_txn(1'b0, 32'h0000_0050, 32'h0, 0, 2, 3, 32'h0BAD_F00D);   // ready beats grant loss
        run_txn(1'b0, 32'h0000_0054, 32'h0, 0, TO, 0, 32'h8888_9999); // ready beats timeout
        run_txn(1'b1, 32'h0000_0058, 32'h0102_0304, 3, 0, 0, 32'h0);  // write timeout

        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 10),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0, $urandom);
        end

        run_txn(1'b0, 32'h0000_0060, 32'h0, 0, 1, 0, 32'hFEED_0001);   // ensure rdata non-zero
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h0000_0020;
        @(negedge clk);
        cmd_valid = 1'b0;
        ack       = 1'b1;
        @(negedge clk);
        check("mid_addr", {32'd0, bus_out}, 64'h20);
        @(negedge clk);
        ctrl_in = 8'h08;
        bus_in  = 32'hA5A5_A5A5;
        rst_L   = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_L   = 1'b1;
        ack     = 1'b0;
        ctrl_in = '0;
        @(negedge clk);
        check("mid_reset_no_pulse", {61'd0, rsp_valid, cmd_ready, req}, 64'b010);
        m_rdata = '0;
        run_txn(1'b1, 32'h0000_0070, 32'h5A5A_5A5A, 1, 2, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
